// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: ALU op encodings, R-type function codes,
// ALU control and multiplier state enums, plus the ALU control decoder.
package cpu_pkg;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluNor,
    AluSlt,
    AluMult,
    AluNone
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    MultIdle,
    MultBusy,
    MultDone
  } mult_state_t;

  // alu_op 11 behaves as add; mult only decodes when the multiplier exists.
  function automatic alu_ctrl_t alu_decode(input logic [1:0] alu_op,
                                           input logic [5:0] funct,
                                           input logic       mult_en);
    alu_ctrl_t ctrl;
    ctrl = AluAdd;
    case (alu_op)
      ALU_OP_ADD: ctrl = AluAdd;
      ALU_OP_SUB: ctrl = AluSub;
      ALU_OP_FUNCT: begin
        case (funct)
          FUNCT_ADD:  ctrl = AluAdd;
          FUNCT_SUB:  ctrl = AluSub;
          FUNCT_AND:  ctrl = AluAnd;
          FUNCT_OR:   ctrl = AluOr;
          FUNCT_NOR:  ctrl = AluNor;
          FUNCT_SLT:  ctrl = AluSlt;
          FUNCT_MULT: ctrl = mult_en ? AluMult : AluNone;
          default:    ctrl = AluNone;
        endcase
      end
      default: ctrl = AluAdd;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/iter_mult.sv
// Iterative shift-add multiplier, one partial product per BUSY cycle.
// busy is combinational so the front of the pipeline freezes in the start cycle.
module iter_mult
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CntW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

  mult_state_t     state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    busy     = 1'b0;
    unique case (state_q)
      MultIdle: begin
        if (start && !flush) begin
          busy     = 1'b1;
          state_d  = MultBusy;
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
        end
      end
      MultBusy: begin
        busy = 1'b1;
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == CntW'(MULT_CYCLES - 1)) begin
          state_d = MultDone;
        end
      end
      MultDone: state_d = MultIdle;
      default:  state_d = MultIdle;
    endcase
    // A squash abandons the multiply immediately, including the stall.
    if (flush) begin
      state_d = MultIdle;
      busy    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MultIdle;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign done    = (state_q == MultDone);
  assign product = acc_q;

endmodule

// File: rtl/ex_mem_stage.sv
// MIPS execute stage and EX/MEM pipeline register.
// Define EX_MULT_EN to build the iterative multiplier; otherwise mult yields 0 with no stall.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             reg_dest_i,
  input  logic             alu_src_i,
  input  logic             mem_to_reg_i,
  input  logic             reg_write_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic             branch_i,
  input  logic [1:0]       alu_op_i,
  input  logic [4:0]       rt_i,
  input  logic [4:0]       rd_i,
  input  logic [15:0]      imm_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             branch_o,
  output logic             zero_o,
  output logic [WIDTH-1:0] alu_result_o,
  output logic [WIDTH-1:0] branch_target_o,
  output logic [WIDTH-1:0] store_data_o,
  output logic [4:0]       write_reg_o
);

  if (WIDTH != 32 || MULT_CYCLES != WIDTH) begin : g_cfg_check
    $error("ex_mem_stage: WIDTH must be 32 and MULT_CYCLES must equal WIDTH");
  end

`ifdef EX_MULT_EN
  localparam logic MultEn = 1'b1;
`else
  localparam logic MultEn = 1'b0;
`endif

  alu_ctrl_t        alu_ctrl;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] result_sel;
  logic [WIDTH-1:0] branch_target;
  logic [4:0]       write_reg;
  logic             capture;

  assign imm_sext      = {{(WIDTH-16){imm_i[15]}}, imm_i};
  assign op_b          = alu_src_i ? imm_sext : rt_data_i;
  assign alu_ctrl      = alu_decode(alu_op_i, funct_i, MultEn);
  assign branch_target = pc_i + (imm_sext << 2);
  assign write_reg     = reg_dest_i ? rd_i : rt_i;

  always_comb begin
    alu_result = '0;
    unique case (alu_ctrl)
      AluAdd:  alu_result = rs_data_i + op_b;
      AluSub:  alu_result = rs_data_i - op_b;
      AluAnd:  alu_result = rs_data_i & op_b;
      AluOr:   alu_result = rs_data_i | op_b;
      AluNor:  alu_result = ~(rs_data_i | op_b);
      AluSlt:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(rs_data_i) < $signed(op_b))};
      AluMult: alu_result = '0;
      AluNone: alu_result = '0;
      default: alu_result = '0;
    endcase
  end

`ifdef EX_MULT_EN
  logic             mult_start;
  logic             mult_busy;
  logic             mult_done;
  logic [WIDTH-1:0] mult_product;

  assign mult_start = valid_i && (alu_ctrl == AluMult);

  iter_mult #(
    .WIDTH       (WIDTH),
    .MULT_CYCLES (MULT_CYCLES)
  ) u_iter_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mult_start),
    .flush   (flush_i),
    .a       (rs_data_i),
    .b       (op_b),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (mult_product)
  );

  // Upstream holds the mult in ID/EX while stalled, so DONE always pairs with it.
  assign stall_o    = mult_busy;
  assign result_sel = mult_done ? mult_product : alu_result;
`else
  assign stall_o    = 1'b0;
  assign result_sel = alu_result;
`endif

  assign capture = valid_i && !flush_i && !stall_o;

  logic             valid_q, mem_to_reg_q, reg_write_q, mem_read_q, mem_write_q, branch_q;
  logic             zero_q;
  logic [WIDTH-1:0] alu_result_q, branch_target_q, store_data_q;
  logic [4:0]       write_reg_q;

  // Bubbles clear only the side-effecting controls; data fields keep their old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q         <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      branch_q        <= 1'b0;
      zero_q          <= 1'b0;
      alu_result_q    <= '0;
      branch_target_q <= '0;
      store_data_q    <= '0;
      write_reg_q     <= '0;
    end else begin
      valid_q     <= capture;
      reg_write_q <= capture & reg_write_i;
      mem_read_q  <= capture & mem_read_i;
      mem_write_q <= capture & mem_write_i;
      branch_q    <= capture & branch_i;
      if (capture) begin
        mem_to_reg_q    <= mem_to_reg_i;
        zero_q          <= (result_sel == '0);
        alu_result_q    <= result_sel;
        branch_target_q <= branch_target;
        store_data_q    <= rt_data_i;
        write_reg_q     <= write_reg;
      end
    end
  end

  assign valid_o         = valid_q;
  assign mem_to_reg_o    = mem_to_reg_q;
  assign reg_write_o     = reg_write_q;
  assign mem_read_o      = mem_read_q;
  assign mem_write_o     = mem_write_q;
  assign branch_o        = branch_q;
  assign zero_o          = zero_q;
  assign alu_result_o    = alu_result_q;
  assign branch_target_o = branch_target_q;
  assign store_data_o    = store_data_q;
  assign write_reg_o     = write_reg_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized bench for ex_mem_stage against a cycle-count reference model.
// Follows EX_MULT_EN so the same bench covers both builds.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, reg_dest_i, alu_src_i, mem_to_reg_i, reg_write_i;
  logic        mem_read_i, mem_write_i, branch_i, flush_i;
  logic [31:0] pc_i, rs_data_i, rt_data_i;
  logic [1:0]  alu_op_i;
  logic [4:0]  rt_i, rd_i;
  logic [15:0] imm_i;
  logic [5:0]  funct_i;
  logic        stall_o, valid_o, mem_to_reg_o, reg_write_o, mem_read_o, mem_write_o;
  logic        branch_o, zero_o;
  logic [31:0] alu_result_o, branch_target_o, store_data_o;
  logic [4:0]  write_reg_o;

  ex_mem_stage #(
    .WIDTH       (32),
    .MULT_CYCLES (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_i         (valid_i),
    .pc_i            (pc_i),
    .reg_dest_i      (reg_dest_i),
    .alu_src_i       (alu_src_i),
    .mem_to_reg_i    (mem_to_reg_i),
    .reg_write_i     (reg_write_i),
    .mem_read_i      (mem_read_i),
    .mem_write_i     (mem_write_i),
    .branch_i        (branch_i),
    .alu_op_i        (alu_op_i),
    .rt_i            (rt_i),
    .rd_i            (rd_i),
    .imm_i           (imm_i),
    .funct_i         (funct_i),
    .rs_data_i       (rs_data_i),
    .rt_data_i       (rt_data_i),
    .flush_i         (flush_i),
    .stall_o         (stall_o),
    .valid_o         (valid_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .reg_write_o     (reg_write_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .branch_o        (branch_o),
    .zero_o          (zero_o),
    .alu_result_o    (alu_result_o),
    .branch_target_o (branch_target_o),
    .store_data_o    (store_data_o),
    .write_reg_o     (write_reg_o)
  );

  always #5 clk = ~clk;

`ifdef EX_MULT_EN
  localparam bit MultOn = 1'b1;
`else
  localparam bit MultOn = 1'b0;
`endif
  localparam int ExpMultStall = MultOn ? 33 : 0;
  localparam logic [31:0] ExpMultRes = MultOn ? 32'h0001_0000 : 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  // Cycles elapsed since the current multiply was first presented; -1 when none.
  int mult_k = -1;
  logic last_stall = 1'b0;

  logic        e_valid, e_mtr, e_rw, e_mr, e_mw, e_br, e_zero;
  logic [31:0] e_res, e_bt, e_sd;
  logic [4:0]  e_wr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext_imm();
    return {{16{imm_i[15]}}, imm_i};
  endfunction

  function automatic logic [31:0] opnd_b();
    return alu_src_i ? sext_imm() : rt_data_i;
  endfunction

  function automatic logic [31:0] ref_alu();
    logic [31:0] a, b;
    a = rs_data_i;
    b = opnd_b();
    if (alu_op_i == 2'b01) return a - b;
    if (alu_op_i != 2'b10) return a + b;
    case (funct_i)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h27:   return ~(a | b);
      6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_prod();
    logic [63:0] p;
    p = {32'h0, rs_data_i} * {32'h0, opnd_b()};
    return p[31:0];
  endfunction

  function automatic int cur_k();
    if (!MultOn) return -1;
    if (mult_k >= 0) return mult_k;
    if (valid_i && alu_op_i == 2'b10 && funct_i == 6'h18) return 0;
    return -1;
  endfunction

  task automatic model_reset();
    {e_valid, e_mtr, e_rw, e_mr, e_mw, e_br, e_zero} = '0;
    e_res = '0; e_bt = '0; e_sd = '0; e_wr = '0;
    mult_k = -1;
  endtask

  task automatic bubble();
    e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_br = 0;
  endtask

  task automatic capture(input logic [31:0] res);
    e_valid = 1; e_mtr = mem_to_reg_i; e_rw = reg_write_i; e_mr = mem_read_i;
    e_mw = mem_write_i; e_br = branch_i;
    e_res = res; e_zero = (res == 32'h0);
    e_bt = pc_i + (sext_imm() << 2);
    e_sd = rt_data_i;
    e_wr = reg_dest_i ? rd_i : rt_i;
  endtask

  task automatic compare_all();
    chk("valid", {31'b0, valid_o}, {31'b0, e_valid});
    chk("mem_to_reg", {31'b0, mem_to_reg_o}, {31'b0, e_mtr});
    chk("reg_write", {31'b0, reg_write_o}, {31'b0, e_rw});
    chk("mem_read", {31'b0, mem_read_o}, {31'b0, e_mr});
    chk("mem_write", {31'b0, mem_write_o}, {31'b0, e_mw});
    chk("branch", {31'b0, branch_o}, {31'b0, e_br});
    chk("zero", {31'b0, zero_o}, {31'b0, e_zero});
    chk("alu_result", alu_result_o, e_res);
    chk("branch_target", branch_target_o, e_bt);
    chk("store_data", store_data_o, e_sd);
    chk("write_reg", {27'b0, write_reg_o}, {27'b0, e_wr});
  endtask

  // Inputs are set at posedge+1; stall is checked at negedge, registers at posedge+1.
  task automatic cycle();
    int k;
    logic exp_stall;
    @(negedge clk);
    k = cur_k();
    exp_stall = !flush_i && k >= 0 && k <= 32;
    last_stall = stall_o;
    chk("stall", {31'b0, stall_o}, {31'b0, exp_stall});
    @(posedge clk);
    if (flush_i) begin
      bubble();
      mult_k = -1;
    end else if (k >= 0 && k <= 32) begin
      bubble();
      mult_k = k + 1;
    end else if (k == 33) begin
      capture(ref_prod());
      mult_k = -1;
    end else if (valid_i) begin
      capture(ref_alu());
    end else begin
      bubble();
    end
    #1;
    compare_all();
  endtask

  task automatic clr_instr();
    valid_i = 0; reg_dest_i = 0; alu_src_i = 0; mem_to_reg_i = 0; reg_write_i = 0;
    mem_read_i = 0; mem_write_i = 0; branch_i = 0; flush_i = 0;
    pc_i = 0; rs_data_i = 0; rt_data_i = 0; alu_op_i = 0; rt_i = 0; rd_i = 0;
    imm_i = 0; funct_i = 0;
  endtask

  task automatic set_mult(input logic [31:0] a, input logic [31:0] b);
    clr_instr();
    valid_i = 1; alu_op_i = 2'b10; funct_i = 6'h18; rs_data_i = a; rt_data_i = b;
    reg_dest_i = 1; rd_i = 5'd5; reg_write_i = 1;
  endtask

  task automatic rand_instr();
    logic [5:0] fl [8];
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h18, 6'h00};
    fl[7] = 6'($urandom);
    valid_i      = ($urandom_range(0, 7) != 0);
    alu_op_i     = 2'($urandom);
    funct_i      = fl[$urandom_range(0, 7)];
    alu_src_i    = 1'($urandom);
    reg_dest_i   = 1'($urandom);
    mem_to_reg_i = 1'($urandom);
    reg_write_i  = 1'($urandom);
    mem_read_i   = 1'($urandom);
    mem_write_i  = 1'($urandom);
    branch_i     = 1'($urandom);
    pc_i         = $urandom;
    rs_data_i    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
    rt_data_i    = ($urandom_range(0, 3) == 0) ? rs_data_i : $urandom;
    rt_i         = 5'($urandom);
    rd_i         = 5'($urandom);
    imm_i        = 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_st, n_bub, guard;
    rst_n = 0;
    clr_instr();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("reset_stall", {31'b0, stall_o}, 32'd0);
    chk("reset_result", alu_result_o, 32'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;

    // add 5 + 7 -> rd 3
    clr_instr();
    valid_i = 1; alu_op_i = 2'b10; funct_i = 6'h20; rs_data_i = 5; rt_data_i = 7;
    reg_dest_i = 1; rd_i = 3; rt_i = 9; reg_write_i = 1;
    cycle();
    chk("add_res", alu_result_o, 32'd12);
    chk("add_wr", {27'b0, write_reg_o}, 32'd3);
    chk("add_rw", {31'b0, reg_write_o}, 32'd1);
    chk("add_zero", {31'b0, zero_o}, 32'd0);

    // beq equal operands, backward target
    clr_instr();
    valid_i = 1; alu_op_i = 2'b01; rs_data_i = 32'h1234; rt_data_i = 32'h1234;
    pc_i = 32'h100; imm_i = 16'hFFFE; branch_i = 1;
    cycle();
    chk("beq_zero", {31'b0, zero_o}, 32'd1);
    chk("beq_target", branch_target_o, 32'h0000_00F8);
    chk("beq_branch", {31'b0, branch_o}, 32'd1);

    // signed slt
    clr_instr();
    valid_i = 1; alu_op_i = 2'b10; funct_i = 6'h2A; rs_data_i = 32'hFFFF_FFFF; rt_data_i = 1;
    cycle();
    chk("slt_res", alu_result_o, 32'd1);

    // sw address with negative immediate
    clr_instr();
    valid_i = 1; alu_op_i = 2'b00; alu_src_i = 1; imm_i = 16'h8000; rs_data_i = 32'h10;
    rt_data_i = 32'hCAFE_BABE; mem_write_i = 1;
    cycle();
    chk("sw_addr", alu_result_o, 32'hFFFF_8010);
    chk("sw_data", store_data_o, 32'hCAFE_BABE);
    chk("sw_mw", {31'b0, mem_write_o}, 32'd1);

    // full multiply: stall window and bubble count
    set_mult(32'h0001_0000, 32'h0003_0001);
    n_st = 0; n_bub = 0; guard = 0;
    do begin
      cycle();
      if (last_stall) begin
        n_st++;
        if (!valid_o) n_bub++;
      end
      guard++;
    end while (last_stall && guard < 40);
    chk("mult_stall_cycles", 32'(n_st), 32'(ExpMultStall));
    chk("mult_bubbles", 32'(n_bub), 32'(ExpMultStall));
    chk("mult_res", alu_result_o, ExpMultRes);
    chk("mult_valid", {31'b0, valid_o}, 32'd1);

    // flush during BUSY cycle 10
    set_mult(32'd3, 32'd4);
    repeat (10) cycle();
    flush_i = 1;
    cycle();
    chk("flush_stall", {31'b0, last_stall}, 32'd0);
    chk("flush_bubble", {31'b0, valid_o}, 32'd0);
    clr_instr();
    valid_i = 1; alu_op_i = 2'b00; rs_data_i = 2; rt_data_i = 2;
    cycle();
    chk("post_flush_stall", {31'b0, last_stall}, 32'd0);
    chk("post_flush_res", alu_result_o, 32'd4);

    // flush wins over a valid instruction
    valid_i = 1; flush_i = 1; reg_write_i = 1;
    cycle();
    chk("flush_valid", {31'b0, valid_o}, 32'd0);
    chk("flush_rw", {31'b0, reg_write_o}, 32'd0);

    // mult with valid low never starts
    set_mult(32'd9, 32'd9);
    valid_i = 0;
    cycle();
    chk("invalid_mult_stall", {31'b0, last_stall}, 32'd0);
    chk("invalid_mult_valid", {31'b0, valid_o}, 32'd0);

    // random traffic; inputs held while the previous cycle stalled
    flush_i = 0;
    last_stall = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) rand_instr();
      flush_i = ($urandom_range(0, 63) == 0);
      cycle();
    end

    // asynchronous reset in the middle of a multiply
    set_mult(32'h1234_5678, 32'h0000_0077);
    repeat (5) cycle();
    #2;
    rst_n = 0;
    valid_i = 0;
    #1;
    chk("amid_valid", {31'b0, valid_o}, 32'd0);
    chk("amid_rw", {31'b0, reg_write_o}, 32'd0);
    chk("amid_res", alu_result_o, 32'd0);
    chk("amid_bt", branch_target_o, 32'd0);
    chk("amid_sd", store_data_o, 32'd0);
    chk("amid_wr", {27'b0, write_reg_o}, 32'd0);
    chk("amid_stall", {31'b0, stall_o}, 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    clr_instr();
    valid_i = 1; alu_op_i = 2'b10; funct_i = 6'h25; rs_data_i = 32'hF0; rt_data_i = 32'h0F;
    cycle();
    chk("post_reset_stall", {31'b0, last_stall}, 32'd0);
    chk("post_reset_or", alu_result_o, 32'h0000_00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
